// File: rtl/rd_stream_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
package rd_stream_pkg;

    localparam int BUF_DEPTH      = 2;
    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        B_EMPTY = 2'd0,
        B_ONE   = 2'd1,
        B_TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/rd_stream_buf.sv
// Two-entry ordered word store; entry 0 is always the oldest word.
// Occupancy comes from the owner's FSM, so the store keeps no flags of its own.
module rd_stream_buf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    input  logic [1:0]            cnt,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] e0_q, e0_d;
    logic [DATA_WIDTH-1:0] e1_q, e1_d;
    logic [1:0]            slot;

    always_comb begin
        e0_d = e0_q;
        e1_d = e1_q;
        slot = cnt - {1'b0, pop};
        if (pop) begin
            e0_d = e1_q;
        end
        // Write lands behind whatever survives this cycle's pop.
        if (wr) begin
            if (slot == 2'd0) begin
                e0_d = wdata;
            end else begin
                e1_d = wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e0_q <= '0;
            e1_q <= '0;
        end else begin
            e0_q <= e0_d;
            e1_q <= e1_d;
        end
    end

    assign head = e0_q;

endmodule

// File: rtl/rd_stream_adapter.sv
// Turns the FIFO's empty/r_en/rdata (1-cycle read latency) into a valid/ready stream.
// Define RD_STREAM_PERF_EN to add the stall_cnt backpressure counter port.
module rd_stream_adapter
    import rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = rd_stream_pkg::DATA_WIDTH_DEF,
    parameter int BUF_DEPTH  = rd_stream_pkg::BUF_DEPTH
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  empty,
    output logic                  r_en,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
`ifdef RD_STREAM_PERF_EN
    output logic [15:0]           stall_cnt,
`endif
    output logic [1:0]            level
);

    buf_state_e state_q, state_d;
    logic       rd_pend_q, rd_pend_d;
    logic       pop, wr;
    logic [2:0] occ;

    assign pop = m_valid & m_ready;
    assign wr  = rd_pend_q;

    // Count in-flight reads as occupied so a returning word always has a slot.
    always_comb begin
        occ       = {1'b0, level} + {2'b00, rd_pend_q} - {2'b00, pop};
        r_en      = !rrst && !empty && (occ < 3'(BUF_DEPTH));
        rd_pend_d = r_en;
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q   <= B_EMPTY;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            B_EMPTY: if (wr && !pop) state_d = B_ONE;
            B_ONE: begin
                if (wr && !pop)      state_d = B_TWO;
                else if (!wr && pop) state_d = B_EMPTY;
            end
            B_TWO:   if (!wr && pop) state_d = B_ONE;
            default: state_d = B_EMPTY;
        endcase
    end

    always_comb begin
        m_valid = (state_q != B_EMPTY);
        level   = state_q;
    end

    rd_stream_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk   (rclk),
        .rst   (rrst),
        .wr    (wr),
        .wdata (rdata),
        .pop   (pop),
        .cnt   (level),
        .head  (m_data)
    );

`ifdef RD_STREAM_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (m_valid && !m_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rd_stream_adapter.sv
// Random and directed stimulus for rd_stream_adapter against a queue-based model
// of the upstream FIFO and of the words the adapter should be holding.
module tb_rd_stream_adapter;

    localparam int DW = 8;

    logic          rclk = 1'b0;
    logic          rrst = 1'b1;
    logic          empty = 1'b1;
    logic          r_en;
    logic [DW-1:0] rdata = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [1:0]    level;
`ifdef RD_STREAM_PERF_EN
    logic [15:0]   stall_cnt;
`endif

    always #5 rclk = ~rclk;

    rd_stream_adapter #(.DATA_WIDTH(DW), .BUF_DEPTH(2)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .empty     (empty),
        .r_en      (r_en),
        .rdata     (rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
`ifdef RD_STREAM_PERF_EN
        .stall_cnt (stall_cnt),
`endif
        .level     (level)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] src_q[$];   // upstream FIFO contents not yet read
    logic [DW-1:0] exp_q[$];   // words the adapter must currently hold, oldest first
    bit            pend = 0;   // a read was issued last cycle
    logic [DW-1:0] rd_word = '0;
    bit            rd_word_v = 0;
    int            cyc_n = 0;
    int            vcnt = 0, vfirst = -1, vlast = -1, rfirst = -1;
    int            stall_m = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, want, cyc_n);
        end
    endtask

    // One clock: entered just after a falling edge, returns at the next one.
    task automatic cyc();
        bit ren_s, pop_m, exp_ren;
        int occ;
        empty = (src_q.size() == 0);
        rdata = rd_word_v ? rd_word : DW'($urandom);
        #1;
        pop_m   = (exp_q.size() > 0) && m_ready;
        occ     = exp_q.size() + int'(pend) - int'(pop_m);
        exp_ren = !rrst && !empty && (occ < 2);
        chk("r_en", 32'(r_en), 32'(exp_ren));
        chk("m_valid", 32'(m_valid), 32'(exp_q.size() > 0));
        chk("level", 32'(level), 32'(exp_q.size()));
        if (exp_q.size() > 0) chk("m_data", 32'(m_data), 32'(exp_q[0]));
        if (m_valid) begin
            vcnt++;
            if (vfirst < 0) vfirst = cyc_n;
            vlast = cyc_n;
        end
        if (r_en && rfirst < 0) rfirst = cyc_n;
        ren_s = r_en;
        @(posedge rclk);
        if (rrst) begin
            exp_q.delete();
            pend      = 0;
            rd_word_v = 0;
            stall_m   = 0;
        end else begin
            if (exp_q.size() > 0 && !m_ready && stall_m < 65535) stall_m++;
            if (pop_m) void'(exp_q.pop_front());
            if (pend && rd_word_v) exp_q.push_back(rd_word);
            rd_word_v = 0;
            if (ren_s && src_q.size() > 0) begin
                rd_word   = src_q.pop_front();
                rd_word_v = 1;
            end
            pend = ren_s;
        end
        cyc_n++;
        @(negedge rclk);
    endtask

    task automatic mark();
        vcnt = 0; vfirst = -1; vlast = -1; rfirst = -1;
    endtask

    initial begin
        @(negedge rclk);
        rrst = 1'b1;
        repeat (3) cyc();
        chk("rst_mdata", 32'(m_data), 32'h0);
        chk("rst_ren", 32'(r_en), 32'h0);
        rrst = 1'b0;

        // single word
        m_ready = 1'b1;
        mark();
        src_q.push_back(8'hA5);
        repeat (6) cyc();
        chk("single_lat", 32'(vfirst - rfirst), 32'd2);
        chk("single_cnt", 32'(vcnt), 32'd1);
        chk("single_lvl", 32'(level), 32'd0);

        // backpressure
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) src_q.push_back(DW'(i));
        repeat (8) cyc();
        chk("bp_level", 32'(level), 32'd2);
        chk("bp_ren", 32'(r_en), 32'd0);
        chk("bp_data", 32'(m_data), 32'h01);
        m_ready = 1'b1;
        repeat (10) cyc();
        chk("bp_drain", 32'(level), 32'd0);

        // full throughput, steady state exercises write+pop in B_ONE
        mark();
        for (int i = 0; i < 16; i++) src_q.push_back(DW'(8'h40 + i));
        repeat (22) cyc();
        chk("tput_cnt", 32'(vcnt), 32'd16);
        chk("tput_run", 32'(vlast - vfirst + 1), 32'd16);
        chk("tput_lat", 32'(vfirst - rfirst), 32'd2);

        // reset with a full buffer
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) src_q.push_back(DW'(8'hC0 + i));
        repeat (6) cyc();
        chk("mrst_pre", 32'(level), 32'd2);
        rrst = 1'b1;
        cyc();
        rrst = 1'b0;
        chk("mrst_lvl", 32'(level), 32'd0);
        chk("mrst_vld", 32'(m_valid), 32'd0);
        m_ready = 1'b1;
        repeat (12) cyc();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) src_q.push_back(DW'($urandom));
            rrst = ($urandom_range(0, 249) == 0);
            cyc();
        end
        rrst = 1'b0;
        m_ready = 1'b1;
        while (src_q.size() > 0 && cyc_n < 90000) cyc();
        repeat (6) cyc();
        chk("final_lvl", 32'(level), 32'd0);

`ifdef RD_STREAM_PERF_EN
        rrst = 1'b1;
        cyc();
        rrst = 1'b0;
        m_ready = 1'b0;
        src_q.push_back(8'h11);
        while (stall_m < 10 && cyc_n < 90000) cyc();
        chk("stall_cnt", 32'(stall_cnt), 32'd10);
        m_ready = 1'b1;
        repeat (4) cyc();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
